// File: rtl/i2c_txn_scheduler.sv
// I2C transaction scheduler: sequences START/address/data/STOP commands for a bit-level I2C core.
// Define I2C_SCHED_REPEAT_START_EN to chain transactions with a repeated START instead of STOP.
module i2c_txn_scheduler #(
  parameter int COUNTWIDTH = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_enable,
  input  logic                  cmd_repeat_start,
  input  logic                  cmd_abort,
  input  logic [6:0]            slave_addr,
  input  logic                  rw_bit,
  input  logic [COUNTWIDTH-1:0] byte_count,
  input  logic                  tx_empty,
  input  logic [7:0]            tx_data,
  output logic                  tx_rd_en,
  input  logic                  rx_full,
  output logic [7:0]            rx_wdata,
  output logic                  rx_wr_en,
  output logic [2:0]            core_cmd,
  output logic                  core_cmd_valid,
  input  logic                  core_cmd_ready,
  output logic [7:0]            core_wdata,
  input  logic                  core_done,
  input  logic                  core_nack,
  input  logic [7:0]            core_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  nack_err
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_ADDR  = 4'd2;
  localparam logic [3:0] ST_FETCH = 4'd3;
  localparam logic [3:0] ST_LOAD  = 4'd4;
  localparam logic [3:0] ST_WBYTE = 4'd5;
  localparam logic [3:0] ST_RBYTE = 4'd6;
  localparam logic [3:0] ST_PUSH  = 4'd7;
  localparam logic [3:0] ST_STOP  = 4'd8;

  localparam logic [2:0] CMD_START     = 3'd0;
  localparam logic [2:0] CMD_RSTART    = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_ACK  = 3'd3;
  localparam logic [2:0] CMD_READ_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  logic [3:0]            state_r;
  logic                  en_q_r;
  logic [6:0]            addr_r;
  logic                  rw_r;
  logic [COUNTWIDTH-1:0] cnt_r;
  logic                  abort_r;

  logic       en_rise_s;
  logic       cmd_done_s;
  logic       abort_s;
  logic       last_s;
  logic       chain_s;
  logic [3:0] fin_state_s;
  logic [2:0] fin_cmd_s;

  assign en_rise_s  = cmd_enable & ~en_q_r;
  // Completion only counts once the command has been handed over (valid already dropped).
  assign cmd_done_s = core_done & ~core_cmd_valid;
  assign abort_s    = abort_r | cmd_abort;
  assign last_s     = (cnt_r == COUNTWIDTH'(1));

`ifdef I2C_SCHED_REPEAT_START_EN
  assign chain_s = cmd_repeat_start & cmd_enable;
`else
  logic unused_repeat_s;
  assign unused_repeat_s = cmd_repeat_start;
  assign chain_s         = 1'b0;
`endif

  assign fin_state_s = chain_s ? ST_START : ST_STOP;
  assign fin_cmd_s   = chain_s ? CMD_RSTART : CMD_STOP;

  // Transaction sequencer; every output is a register written here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r        <= ST_IDLE;
      en_q_r         <= 1'b0;
      addr_r         <= 7'd0;
      rw_r           <= 1'b0;
      cnt_r          <= {COUNTWIDTH{1'b0}};
      abort_r        <= 1'b0;
      core_cmd       <= 3'd0;
      core_cmd_valid <= 1'b0;
      core_wdata     <= 8'd0;
      tx_rd_en       <= 1'b0;
      rx_wr_en       <= 1'b0;
      rx_wdata       <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      nack_err       <= 1'b0;
    end else begin
      en_q_r   <= cmd_enable;
      tx_rd_en <= 1'b0;
      rx_wr_en <= 1'b0;
      done     <= 1'b0;
      if (core_cmd_valid && core_cmd_ready) core_cmd_valid <= 1'b0;
      if (cmd_abort && (state_r != ST_IDLE) && (state_r != ST_STOP)) abort_r <= 1'b1;

      case (state_r)
        ST_IDLE: begin
          if (en_rise_s) begin
            state_r        <= ST_START;
            busy           <= 1'b1;
            nack_err       <= 1'b0;
            abort_r        <= 1'b0;
            core_cmd       <= CMD_START;
            core_cmd_valid <= 1'b1;
            addr_r         <= slave_addr;
            rw_r           <= rw_bit;
            cnt_r          <= byte_count;
          end
        end
        ST_START: begin
          // An abort before the core takes the START leaves the bus untouched.
          if (core_cmd_valid && !core_cmd_ready && cmd_abort) begin
            state_r        <= ST_IDLE;
            busy           <= 1'b0;
            core_cmd_valid <= 1'b0;
            abort_r        <= 1'b0;
          end else if (cmd_done_s) begin
            core_cmd_valid <= 1'b1;
            if (abort_s) begin
              state_r  <= ST_STOP;
              core_cmd <= CMD_STOP;
              abort_r  <= 1'b0;
            end else begin
              state_r    <= ST_ADDR;
              core_cmd   <= CMD_WRITE;
              core_wdata <= {addr_r, rw_r};
            end
          end
        end
        ST_ADDR: begin
          if (cmd_done_s) begin
            if (core_nack || abort_s) begin
              nack_err       <= nack_err | core_nack;
              state_r        <= ST_STOP;
              core_cmd       <= CMD_STOP;
              core_cmd_valid <= 1'b1;
              abort_r        <= 1'b0;
            end else if (cnt_r == {COUNTWIDTH{1'b0}}) begin
              state_r        <= fin_state_s;
              core_cmd       <= fin_cmd_s;
              core_cmd_valid <= 1'b1;
              if (chain_s) begin
                addr_r <= slave_addr;
                rw_r   <= rw_bit;
                cnt_r  <= byte_count;
              end
            end else if (rw_r) begin
              state_r        <= ST_RBYTE;
              core_cmd       <= last_s ? CMD_READ_NACK : CMD_READ_ACK;
              core_cmd_valid <= 1'b1;
            end else begin
              state_r <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (abort_s) begin
            state_r        <= ST_STOP;
            core_cmd       <= CMD_STOP;
            core_cmd_valid <= 1'b1;
            abort_r        <= 1'b0;
          end else if (!tx_empty) begin
            tx_rd_en <= 1'b1;
            state_r  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // tx_data is only valid the cycle after the pop pulse.
          if (!tx_rd_en) begin
            core_wdata     <= tx_data;
            core_cmd       <= CMD_WRITE;
            core_cmd_valid <= 1'b1;
            state_r        <= ST_WBYTE;
          end
        end
        ST_WBYTE: begin
          if (cmd_done_s) begin
            if (core_nack || abort_s) begin
              nack_err       <= nack_err | core_nack;
              state_r        <= ST_STOP;
              core_cmd       <= CMD_STOP;
              core_cmd_valid <= 1'b1;
              abort_r        <= 1'b0;
            end else if (last_s) begin
              state_r        <= fin_state_s;
              core_cmd       <= fin_cmd_s;
              core_cmd_valid <= 1'b1;
              if (chain_s) begin
                addr_r <= slave_addr;
                rw_r   <= rw_bit;
                cnt_r  <= byte_count;
              end
            end else begin
              cnt_r   <= cnt_r - COUNTWIDTH'(1);
              state_r <= ST_FETCH;
            end
          end
        end
        ST_RBYTE: begin
          if (cmd_done_s) begin
            if (abort_s) begin
              state_r        <= ST_STOP;
              core_cmd       <= CMD_STOP;
              core_cmd_valid <= 1'b1;
              abort_r        <= 1'b0;
            end else begin
              rx_wdata <= core_rdata;
              state_r  <= ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          if (abort_s) begin
            state_r        <= ST_STOP;
            core_cmd       <= CMD_STOP;
            core_cmd_valid <= 1'b1;
            abort_r        <= 1'b0;
          end else if (!rx_full) begin
            rx_wr_en       <= 1'b1;
            core_cmd_valid <= 1'b1;
            if (last_s) begin
              state_r  <= fin_state_s;
              core_cmd <= fin_cmd_s;
              if (chain_s) begin
                addr_r <= slave_addr;
                rw_r   <= rw_bit;
                cnt_r  <= byte_count;
              end
            end else begin
              cnt_r    <= cnt_r - COUNTWIDTH'(1);
              state_r  <= ST_RBYTE;
              core_cmd <= (cnt_r == COUNTWIDTH'(2)) ? CMD_READ_NACK : CMD_READ_ACK;
            end
          end
        end
        ST_STOP: begin
          if (cmd_done_s) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            abort_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          busy           <= 1'b0;
          core_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_txn_scheduler.md
I2C_TXN_SCHEDULER -- requirements
Module: i2c_txn_scheduler

Interface
REQ-001 SHALL have parameter COUNTWIDTH, default 4: width of byte_count; 0 = address-only transaction.
REQ-002 SHALL have PCLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have PRESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have cmd_enable  input  1  rising edge starts a transaction.
REQ-005 SHALL have cmd_repeat_start  input  1  chain the next transaction with a repeated START.
REQ-006 SHALL have cmd_abort  input  1  synchronous abort request.
REQ-007 SHALL have slave_addr  input  7  target I2C address.
REQ-008 SHALL have rw_bit  input  1  1=read, 0=write.
REQ-009 SHALL have byte_count  input  COUNTWIDTH  data bytes per transaction.
REQ-010 SHALL have tx_empty  input  1  TX FIFO empty.
REQ-011 SHALL have tx_data  input  8  TX FIFO head, valid the cycle after tx_rd_en.
REQ-012 SHALL have tx_rd_en  output  1  TX FIFO pop, one-cycle pulse.
REQ-013 SHALL have rx_full  input  1  RX FIFO full.
REQ-014 SHALL have rx_wdata  output  8  byte to RX FIFO.
REQ-015 SHALL have rx_wr_en  output  1  RX FIFO push, one-cycle pulse.
REQ-016 SHALL have core_cmd  output  3  0=START, 1=RSTART, 2=WRITE, 3=READ_ACK, 4=READ_NACK, 5=STOP.
REQ-017 SHALL have core_cmd_valid  output  1  command offered to the bit-level core.
REQ-018 SHALL have core_cmd_ready  input  1  core accepts the command.
REQ-019 SHALL have core_wdata  output  8  byte for a WRITE command.
REQ-020 SHALL have core_done  input  1  one-cycle pulse when the accepted command completes.
REQ-021 SHALL have core_nack  input  1  slave NACK, qualified by core_done.
REQ-022 SHALL have core_rdata  input  8  received byte, qualified by core_done.
REQ-023 SHALL have busy  output  1  state != IDLE.
REQ-024 SHALL have done  output  1  one-cycle pulse when STOP completes.
REQ-025 SHALL have nack_err  output  1  sticky NACK flag, cleared at next START.

Function
REQ-026 FSM states SHALL be: IDLE, START, ADDR, FETCH, LOAD, WBYTE, RBYTE, PUSH, STOP.
REQ-027 IDLE->START SHALL occur on the cycle after cmd_enable is sampled 0->1; core_cmd_valid=1 with START is asserted in that START state.
REQ-028 Each command SHALL be held with valid and stable data until valid&ready; valid then drops, and the FSM waits for core_done before advancing.
REQ-029 ADDR SHALL issue WRITE with core_wdata={slave_addr,rw_bit}; these inputs, together with byte_count, are latched at START.
REQ-030 Write path: FETCH stalls while tx_empty, else pulses tx_rd_en; LOAD captures tx_data; WBYTE issues WRITE; loop until byte_count bytes are sent.
REQ-031 Read path: RBYTE issues READ_ACK, or READ_NACK for the last byte; PUSH holds while rx_full, then pulses rx_wr_en with rx_wdata=core_rdata.
REQ-032 byte_count=0 SHALL go ADDR->STOP with no FIFO access.
REQ-033 core_done&core_nack on an ADDR or WBYTE command SHALL set nack_err and go to STOP; unsent TX bytes are not popped.
REQ-034 cmd_abort SHALL force IDLE from START (before acceptance); from any later state it SHALL force STOP after the in-flight command's core_done.
REQ-035 After STOP's core_done: done=1 for one cycle, then IDLE; a new transaction needs a fresh cmd_enable rising edge.

Reset
REQ-036 PRESET SHALL immediately force IDLE and drive every output to 0 (core_cmd=0, tx_rd_en=0, rx_wr_en=0, busy=0, done=0, nack_err=0), clear the byte counter, and clear the enable-edge register to 0.
REQ-037 Reset mid-transaction SHALL issue no STOP; the core is reset by the same PRESET.

Configuration
REQ-038 With I2C_SCHED_REPEAT_START_EN defined, cmd_repeat_start=1 and cmd_enable=1 at transaction end SHALL skip STOP, issue RSTART, relatch inputs, and go to ADDR without pulsing done; without the macro, cmd_repeat_start SHALL be ignored and every transaction ends in STOP.

Verification
REQ-039 Write: addr 0x50, rw=0, count=2, FIFO {0xA5,0x3C} -> cmds START, WRITE 0xA0, WRITE 0xA5, WRITE 0x3C, STOP; two tx_rd_en pulses; done once.
REQ-040 Read: addr 0x29, rw=1, count=3, core_rdata 0x11,0x22,0x33 -> WRITE 0x53, READ_ACK x2, READ_NACK, STOP; rx_wdata 0x11,0x22,0x33.
REQ-041 NACK: core_nack on ADDR -> nack_err=1, next command is STOP, no tx_rd_en; nack_err=0 after the next START.
REQ-042 Stalls: tx_empty held 10 cycles in FETCH, rx_full held 5 cycles in PUSH -> no pops or pushes during the stall, correct data afterwards.
REQ-043 Abort/reset: cmd_abort during the 2nd WBYTE -> STOP after core_done; PRESET mid-RBYTE -> all outputs 0 at once, busy=0.
REQ-044 With the macro defined and repeat_start=1, back-to-back write->read -> RSTART between them, a single STOP, and a single done pulse.
